// File: rtl/plru_pkg.sv
// Shared sizing and index types for the dcache tree-PLRU state store.
package plru_pkg;
    localparam int PLRU_WAYS   = 8;
    localparam int PLRU_SETS   = 16;
    localparam int PLRU_WAY_W  = $clog2(PLRU_WAYS);
    localparam int PLRU_SET_W  = $clog2(PLRU_SETS);
    localparam int PLRU_BITS_W = PLRU_WAYS - 1;

    typedef logic [PLRU_WAY_W-1:0]  way_idx_t;
    typedef logic [PLRU_SET_W-1:0]  set_idx_t;
    typedef logic [PLRU_BITS_W-1:0] plru_bits_t;
endpackage

// File: rtl/plru_path_update.sv
// Rewrites the tree bits on the root-to-leaf path of a touched way so each points away from it.
module plru_path_update
    import plru_pkg::*;
#(
    parameter  int WAYS  = PLRU_WAYS,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  i_bits,
    input  logic [WAY_W-1:0] i_way,
    output logic [WAYS-2:0]  o_bits
);
    // Node at level l, offset o is on the path when the top l way bits equal o.
    for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
        for (genvar o = 0; o < (1 << l); o++) begin : g_node
            localparam int N = (1 << l) - 1 + o;
            if (l == 0) begin : g_root
                assign o_bits[N] = ~i_way[WAY_W-1];
            end else begin : g_inner
                logic w_on_path;
                assign w_on_path = (int'(i_way[WAY_W-1 -: l]) == o);
                assign o_bits[N] = w_on_path ? ~i_way[WAY_W-1-l] : i_bits[N];
            end
        end
    end
endmodule

// File: rtl/plru_tree.sv
// Tree-PLRU victim decoder: follows bit[n] from the root (0 -> 2n+1, 1 -> 2n+2) to a leaf.
module plru_tree #(
    parameter  int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  i_bits,
    output logic [WAY_W-1:0] o_way
);
    logic [2*WAYS-1:0] w_bits_ext;
    logic [WAY_W:0]    w_node;

    // Zero padding lets the node index address the vector at its natural width.
    assign w_bits_ext = {{(WAYS+1){1'b0}}, i_bits};

    always_comb begin
        w_node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            w_node = {w_node[WAY_W-1:0], 1'b0} + {{WAY_W{1'b0}}, 1'b1}
                   + {{WAY_W{1'b0}}, w_bits_ext[w_node]};
        end
    end

    // Leaf node is WAYS-1+j, and WAYS-1 is -1 modulo WAYS.
    assign o_way = w_node[WAY_W-1:0] + WAY_W'(1);
endmodule

// File: rtl/plru_state_array.sv
// Per-set tree-PLRU bit store with path update on access and a one-cycle registered victim lookup.
module plru_state_array
    import plru_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       access_valid_i,
    input  set_idx_t   access_set_i,
    input  way_idx_t   access_way_i,
    input  logic       victim_req_i,
    input  set_idx_t   victim_set_i,
    output logic       victim_valid_o,
    output way_idx_t   victim_way_o,
    output plru_bits_t plru_bits_o
);
    plru_bits_t r_bits [PLRU_SETS];
    plru_bits_t w_cur_bits;
    plru_bits_t w_next_bits;
    plru_bits_t w_lk_bits;
    way_idx_t   w_lk_way;
    logic       r_valid;
    way_idx_t   r_way;
    plru_bits_t r_plru_bits;

    assign w_cur_bits = r_bits[access_set_i];

    plru_path_update #(.WAYS(PLRU_WAYS)) u_path_update (
        .i_bits (w_cur_bits),
        .i_way  (access_way_i),
        .o_bits (w_next_bits)
    );

    // Same-set access in the lookup cycle: return the bits being written this edge.
    assign w_lk_bits = (access_valid_i && (access_set_i == victim_set_i))
                     ? w_next_bits : r_bits[victim_set_i];

    plru_tree #(.WAYS(PLRU_WAYS)) u_tree (
        .i_bits (w_lk_bits),
        .o_way  (w_lk_way)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PLRU_SETS; i++) begin
                r_bits[i] <= '0;
            end
        end else if (access_valid_i) begin
            r_bits[access_set_i] <= w_next_bits;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_way       <= '0;
            r_plru_bits <= '0;
        end else begin
            r_valid <= victim_req_i;
            if (victim_req_i) begin
                r_way       <= w_lk_way;
                r_plru_bits <= w_lk_bits;
            end
        end
    end

    assign victim_valid_o = r_valid;
    assign victim_way_o   = r_way;
    assign plru_bits_o    = r_plru_bits;
endmodule
